// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, multi-cycle shifts and MUL.
// Shifts step one bit per cycle; MUL is an iterative shift-add.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [4:0]       FunSel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             WF,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut,
    output logic             Busy,
    output logic             Done
);

    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int LW = $clog2(WIDTH);
    localparam int LH = $clog2(H);
    localparam logic [WIDTH-1:0] MASK_H = {{H{1'b0}}, {H{1'b1}}};
    localparam logic [WIDTH-1:0] TOP_F  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] TOP_H  = {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [3:0]         op_q;
    logic               full_q, wf_q, carry_q;
    logic [WIDTH-1:0]   work, mplier;
    logic [2*WIDTH-1:0] mcand, acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   mask_in, a_m, b_m, res1, diff;
    logic [WIDTH:0]     sum;
    logic               c1, o1, cin, multi;
    logic [CW-1:0]      n_in;
    logic [3:0]         flags1, flags2;

    logic [WIDTH-1:0]   mask_q, top_q, work_nx, res2;
    logic               wm, carry_nx, c2;

    function automatic logic msb(input logic [WIDTH-1:0] x, input logic f);
        return f ? x[WIDTH-1] : x[H-1];
    endfunction

    assign multi = (FunSel[3:0] >= 4'd11);
    assign cin   = (FunSel[3:0] == 4'd5) & FlagsOut[2];

    always_comb begin
        mask_in = FunSel[4] ? {WIDTH{1'b1}} : MASK_H;
        a_m     = A & mask_in;
        b_m     = B & mask_in;
        sum     = {1'b0, a_m} + {1'b0, b_m} + {{WIDTH{1'b0}}, cin};
        diff    = a_m - b_m;
        res1    = '0;
        c1      = FlagsOut[2];
        o1      = FlagsOut[0];
        case (FunSel[3:0])
            4'd0:  res1 = a_m;
            4'd1:  res1 = b_m;
            4'd2:  res1 = ~A & mask_in;
            4'd3:  res1 = ~B & mask_in;
            4'd4, 4'd5: begin
                res1 = sum[WIDTH-1:0] & mask_in;
                c1   = FunSel[4] ? sum[WIDTH] : sum[H];
                o1   = (msb(a_m, FunSel[4]) == msb(b_m, FunSel[4])) &&
                       (msb(res1, FunSel[4]) != msb(a_m, FunSel[4]));
            end
            4'd6: begin
                res1 = diff & mask_in;
                c1   = a_m < b_m;
                o1   = (msb(a_m, FunSel[4]) != msb(b_m, FunSel[4])) &&
                       (msb(res1, FunSel[4]) != msb(a_m, FunSel[4]));
            end
            4'd7:  res1 = a_m & b_m;
            4'd8:  res1 = a_m | b_m;
            4'd9:  res1 = a_m ^ b_m;
            4'd10: res1 = ~(a_m & b_m) & mask_in;
            default: res1 = '0;
        endcase
        flags1 = {res1 == '0, c1, msb(res1, FunSel[4]), o1};
        n_in   = FunSel[4] ? CW'(B[LW-1:0]) : CW'(B[LH-1:0]);
    end

    // One bit of shift/rotate per RUN step; result bits stay within op width.
    always_comb begin
        mask_q   = full_q ? {WIDTH{1'b1}} : MASK_H;
        top_q    = full_q ? TOP_F : TOP_H;
        wm       = msb(work, full_q);
        work_nx  = work;
        carry_nx = carry_q;
        unique case (1'b1)
            (op_q == 4'd11): begin
                work_nx  = (work << 1) & mask_q;
                carry_nx = wm;
            end
            (op_q == 4'd12): begin
                work_nx  = work >> 1;
                carry_nx = work[0];
            end
            (op_q == 4'd13): begin
                work_nx  = (work >> 1) | (wm ? top_q : '0);
                carry_nx = work[0];
            end
            (op_q == 4'd14): begin
                work_nx  = ((work << 1) | {{(WIDTH-1){1'b0}}, wm}) & mask_q;
                carry_nx = wm;
            end
            default: ;
        endcase
        if (op_q == 4'd15) begin
            res2 = acc[WIDTH-1:0] & mask_q;
            c2   = full_q ? |acc[2*WIDTH-1:WIDTH] : |acc[WIDTH-1:H];
        end else begin
            res2 = work;
            c2   = carry_q;
        end
        flags2 = {res2 == '0, c2, msb(res2, full_q), FlagsOut[0]};
    end

    always_ff @(posedge Clock) begin
        if (!Reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        unique case (state)
            IDLE: if (Start && multi) state_next = RUN;
            RUN: begin
                Busy = 1'b1;
                if (cnt == '0) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ALUOut   <= '0;
            FlagsOut <= '0;
            Done     <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
            full_q   <= 1'b0;
            wf_q     <= 1'b0;
            carry_q  <= 1'b0;
            work     <= '0;
            mplier   <= '0;
            mcand    <= '0;
            acc      <= '0;
        end else begin
            Done <= 1'b0;
            if (state == IDLE && Start) begin
                if (!multi) begin
                    ALUOut <= res1;
                    if (WF) FlagsOut <= flags1;
                    Done <= 1'b1;
                end else begin
                    op_q    <= FunSel[3:0];
                    full_q  <= FunSel[4];
                    wf_q    <= WF;
                    carry_q <= FlagsOut[2];
                    work    <= a_m;
                    mplier  <= b_m;
                    mcand   <= {{WIDTH{1'b0}}, a_m};
                    acc     <= '0;
                    if (FunSel[3:0] == 4'd15)
                        cnt <= FunSel[4] ? CW'(WIDTH) : CW'(H);
                    else
                        cnt <= n_in;
                end
            end else if (state == RUN) begin
                if (cnt != '0) begin
                    cnt     <= cnt - 1'b1;
                    work    <= work_nx;
                    carry_q <= carry_nx;
                    if (mplier[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                end else begin
                    ALUOut <= res2;
                    if (wf_q) FlagsOut <= flags2;
                    Done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: directed scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b0;
    logic         Start = 1'b0;
    logic [4:0]   FunSel = '0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         WF = 1'b0;
    logic [W-1:0] ALUOut;
    logic [3:0]   FlagsOut;
    logic         Busy;
    logic         Done;

    int checks = 0;
    int passes = 0;
    logic [3:0] mflags = 4'b0000;

    seq_alu #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .FunSel(FunSel),
        .A(A), .B(B), .WF(WF), .ALUOut(ALUOut), .FlagsOut(FlagsOut),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    function automatic bit sgn(input longint x, input longint ow);
        return ((x >> (ow - 1)) & 64'd1) != 0;
    endfunction

    // Reference: result, flags and Busy length from plain arithmetic.
    function automatic void model(input logic [4:0] fs, input logic [W-1:0] ai,
                                  input logic [W-1:0] bi, input logic [3:0] fin,
                                  output logic [W-1:0] res, output logic [3:0] fout,
                                  output int lat);
        longint ow, mask, a, b, n, r, s, sa;
        bit c, o;
        ow   = fs[4] ? 64'd16 : 64'd8;
        mask = (64'd1 << ow) - 64'd1;
        a    = {48'b0, ai} & mask;
        b    = {48'b0, bi} & mask;
        n    = b % ow;
        c    = fin[2];
        o    = fin[0];
        lat  = 0;
        r    = 0;
        case (fs[3:0])
            4'd0:  r = a;
            4'd1:  r = b;
            4'd2:  r = ~a & mask;
            4'd3:  r = ~b & mask;
            4'd4, 4'd5: begin
                s = a + b + ((fs[3:0] == 4'd5 && c) ? 64'd1 : 64'd0);
                r = s & mask;
                c = s > mask;
                o = (sgn(a, ow) == sgn(b, ow)) && (sgn(r, ow) != sgn(a, ow));
            end
            4'd6: begin
                r = (a - b) & mask;
                c = a < b;
                o = (sgn(a, ow) != sgn(b, ow)) && (sgn(r, ow) != sgn(a, ow));
            end
            4'd7:  r = a & b;
            4'd8:  r = a | b;
            4'd9:  r = a ^ b;
            4'd10: r = ~(a & b) & mask;
            4'd11: begin
                r = (a << n) & mask;
                if (n > 0) c = ((a >> (ow - n)) & 64'd1) != 0;
                lat = int'(n) + 1;
            end
            4'd12: begin
                r = a >> n;
                if (n > 0) c = ((a >> (n - 1)) & 64'd1) != 0;
                lat = int'(n) + 1;
            end
            4'd13: begin
                sa = sgn(a, ow) ? a - (64'd1 << ow) : a;
                r  = (sa >>> n) & mask;
                if (n > 0) c = ((a >> (n - 1)) & 64'd1) != 0;
                lat = int'(n) + 1;
            end
            4'd14: begin
                r = ((a << n) | (a >> (ow - n))) & mask;
                if (n > 0) c = (r & 64'd1) != 0;
                lat = int'(n) + 1;
            end
            default: begin
                s = a * b;
                r = s & mask;
                c = (s >> ow) != 0;
                lat = int'(ow) + 1;
            end
        endcase
        res  = r[W-1:0];
        fout = {r == 0, c, sgn(r, ow), o};
    endfunction

    // Issues one op and waits (bounded) for Done; optionally pokes
    // a Start with different data while the op is running.
    task automatic run_op(input logic [4:0] fs, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic wf, input bit inject,
                          output int cycles, output int busy);
        FunSel = fs; A = a; B = b; WF = wf; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        cycles = 0;
        busy = 0;
        while (!Done && cycles < 100) begin
            if (Busy) busy++;
            if (inject && cycles == 1) begin
                Start = 1'b1; A = '1; B = 16'h0003; FunSel = 5'b10100;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clock); #1;
            cycles++;
        end
        Start = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        checks++; if (ALUOut !== 16'h0000) $display("FAIL reset_alu: got %h want 0000", ALUOut); else passes++;
        checks++; if (FlagsOut !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", FlagsOut); else passes++;
        checks++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", Busy); else passes++;
        checks++; if (Done !== 1'b0) $display("FAIL reset_done: got %b want 0", Done); else passes++;
        mflags = 4'b0000;
    endtask

    task automatic test_add_overflow;
        int cyc, bz;
        run_op(5'b10100, 16'h7FFF, 16'h0001, 1'b1, 0, cyc, bz);
        checks++; if (ALUOut !== 16'h8000) $display("FAIL add_result: got %h want 8000", ALUOut); else passes++;
        checks++; if (FlagsOut !== 4'b0011) $display("FAIL add_flags: got %b want 0011", FlagsOut); else passes++;
        checks++; if (cyc != 0 || bz != 0) $display("FAIL add_latency: got cyc=%0d busy=%0d want 0/0", cyc, bz); else passes++;
        @(posedge Clock); #1;
        checks++; if (Done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", Done); else passes++;
        mflags = 4'b0011;
    endtask

    task automatic test_sub_half;
        int cyc, bz;
        run_op(5'b00110, 16'h0003, 16'h0005, 1'b1, 0, cyc, bz);
        checks++; if (ALUOut !== 16'h00FE) $display("FAIL sub_result: got %h want 00fe", ALUOut); else passes++;
        checks++; if (FlagsOut !== 4'b0110) $display("FAIL sub_flags: got %b want 0110", FlagsOut); else passes++;
        mflags = 4'b0110;
    endtask

    task automatic test_lsl_busy;
        int cyc, bz;
        run_op(5'b11011, 16'h1234, 16'h0004, 1'b1, 1, cyc, bz);
        checks++; if (bz != 5) $display("FAIL lsl_busy: got %0d want 5", bz); else passes++;
        checks++; if (cyc != 5) $display("FAIL lsl_latency: got %0d want 5", cyc); else passes++;
        checks++; if (ALUOut !== 16'h2340) $display("FAIL lsl_result: got %h want 2340", ALUOut); else passes++;
        checks++; if (FlagsOut !== 4'b0100) $display("FAIL lsl_flags: got %b want 0100", FlagsOut); else passes++;
        @(posedge Clock); #1;
        checks++; if (Done !== 1'b0 || ALUOut !== 16'h2340) $display("FAIL lsl_after: got done=%b alu=%h want 0/2340", Done, ALUOut); else passes++;
        mflags = 4'b0100;
    endtask

    task automatic test_mul;
        int cyc, bz;
        run_op(5'b11111, 16'h0100, 16'h0100, 1'b1, 0, cyc, bz);
        checks++; if (cyc != 17 || bz != 17) $display("FAIL mul_latency: got cyc=%0d busy=%0d want 17/17", cyc, bz); else passes++;
        checks++; if (ALUOut !== 16'h0000) $display("FAIL mul_result: got %h want 0000", ALUOut); else passes++;
        checks++; if (FlagsOut !== 4'b1100) $display("FAIL mul_flags: got %b want 1100", FlagsOut); else passes++;
        run_op(5'b11111, 16'h0100, 16'h0100, 1'b0, 0, cyc, bz);
        checks++; if (FlagsOut !== 4'b1100) $display("FAIL mul_wf0_flags: got %b want 1100", FlagsOut); else passes++;
        run_op(5'b11111, 16'h0003, 16'h0005, 1'b0, 0, cyc, bz);
        checks++; if (ALUOut !== 16'h000F) $display("FAIL mul_wf0_result: got %h want 000f", ALUOut); else passes++;
        checks++; if (FlagsOut !== 4'b1100) $display("FAIL mul_wf0_hold: got %b want 1100", FlagsOut); else passes++;
        mflags = 4'b1100;
    endtask

    task automatic test_back_to_back;
        FunSel = 5'b10100; A = 16'h0001; B = 16'h0002; WF = 1'b0; Start = 1'b1;
        @(posedge Clock); #1;
        checks++; if (ALUOut !== 16'h0003 || Done !== 1'b1) $display("FAIL b2b_first: got %h/%b want 0003/1", ALUOut, Done); else passes++;
        A = 16'h0005; B = 16'h0006;
        @(posedge Clock); #1;
        Start = 1'b0;
        checks++; if (ALUOut !== 16'h000B || Done !== 1'b1) $display("FAIL b2b_second: got %h/%b want 000b/1", ALUOut, Done); else passes++;
        checks++; if (FlagsOut !== mflags) $display("FAIL b2b_flags: got %b want %b", FlagsOut, mflags); else passes++;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset_mid_run;
        int cyc, bz, seen;
        FunSel = 5'b11111; A = 16'h00FF; B = 16'h00FF; WF = 1'b1; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (4) @(posedge Clock);
        #1 Reset = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        checks++; if (ALUOut !== '0 || FlagsOut !== '0) $display("FAIL midrun_outputs: got %h/%b want 0000/0000", ALUOut, FlagsOut); else passes++;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL midrun_ctrl: got busy=%b done=%b want 0/0", Busy, Done); else passes++;
        mflags = 4'b0000;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock); #1;
            if (Done === 1'b1 || Busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) $display("FAIL midrun_no_done: got %0d active cycles want 0", seen); else passes++;
        run_op(5'b10100, 16'h0001, 16'h0001, 1'b1, 0, cyc, bz);
        checks++; if (ALUOut !== 16'h0002) $display("FAIL midrun_next_add: got %h want 0002", ALUOut); else passes++;
        checks++; if (FlagsOut !== 4'b0000) $display("FAIL midrun_next_flags: got %b want 0000", FlagsOut); else passes++;
        mflags = 4'b0000;
    endtask

    task automatic test_random;
        int cyc, bz, lat;
        logic [4:0] fs;
        logic [W-1:0] a, b, er;
        logic [3:0] ef, want;
        logic wf;
        for (int i = 0; i < 80; i++) begin
            fs = 5'($urandom);
            a  = W'($urandom);
            b  = W'($urandom);
            wf = 1'($urandom);
            if ($urandom_range(0, 3) == 0) b[3:0] = 4'd0;
            model(fs, a, b, mflags, er, ef, lat);
            want = wf ? ef : mflags;
            run_op(fs, a, b, wf, 0, cyc, bz);
            checks++; if (ALUOut !== er) $display("FAIL rand_result op=%b a=%h b=%h: got %h want %h", fs, a, b, ALUOut, er); else passes++;
            checks++; if (FlagsOut !== want) $display("FAIL rand_flags op=%b a=%h b=%h: got %b want %b", fs, a, b, FlagsOut, want); else passes++;
            checks++; if (cyc != lat || bz != lat) $display("FAIL rand_latency op=%b: got cyc=%0d busy=%0d want %0d", fs, cyc, bz, lat); else passes++;
            mflags = want;
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_half();
        test_lsl_busy();
        test_mul();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the full operand width; it SHALL be even and at least 4.
REQ-002 The block SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit, request to begin an operation.
REQ-005 The block SHALL have port FunSel, input, 5 bits: bit 4 is the size select (0 = half width WIDTH/2, 1 = full width); bits 3:0 are the opcode.
REQ-006 The block SHALL have ports A and B, input, WIDTH bits each, the operands.
REQ-007 The block SHALL have port WF, input, 1 bit, flag-write enable for the operation.
REQ-008 The block SHALL have port ALUOut, output, WIDTH bits, the registered result.
REQ-009 The block SHALL have port FlagsOut, output, 4 bits, registered {Z,C,N,O}.
REQ-010 The block SHALL have port Busy, output, 1 bit, high while a multi-cycle operation runs.
REQ-011 The block SHALL have port Done, output, 1 bit, one-cycle completion pulse.

Function
REQ-012 Opcodes SHALL be: 0 A; 1 B; 2 NOT A; 3 NOT B; 4 A+B; 5 A+B+C; 6 A-B; 7 AND; 8 OR; 9 XOR; 10 NAND; 11 LSL A by n; 12 LSR A by n; 13 ASR A by n; 14 ROL A by n; 15 MUL A*B, keeping the low half of the product.
REQ-013 The op width SHALL be WIDTH/2 or WIDTH per FunSel[4]; only the low op-width bits of A and B are used; result bits above op width SHALL be 0.
REQ-014 For opcodes 11-14, n SHALL be B[log2(opwidth)-1:0].
REQ-015 The FSM SHALL have states IDLE and RUN; Start SHALL be accepted only in IDLE, and Start while Busy=1 SHALL be ignored.
REQ-016 Opcodes 0-10 SHALL complete on the accepting edge: ALUOut and flags update, Done=1 the next cycle, state stays IDLE, Busy stays 0.
REQ-017 Opcodes 11-15 SHALL, on the accepting edge, latch A, B, FunSel, WF and the current C, load counter = n (shifts) or opwidth (MUL), and enter RUN.
REQ-018 In RUN with counter>0, each edge SHALL perform one step (one 1-bit shift/rotate, or one shift-add iteration) and decrement the counter.
REQ-019 In RUN with counter=0, the edge SHALL write ALUOut and flags and return to IDLE; Done=1 the following cycle.
REQ-020 Multi-cycle latency SHALL be n+1 cycles for shifts and opwidth+1 for MUL; Busy SHALL be high for exactly those cycles.
REQ-021 Input changes during RUN SHALL have no effect.
REQ-022 Z SHALL equal (result==0) and N SHALL equal the result MSB at op width, for every opcode.
REQ-023 C and O SHALL hold for opcodes 0-3 and 7-10.
REQ-024 For ADD/ADC, C SHALL be the carry out and O SHALL be signed overflow; ADC SHALL use the C value sampled at acceptance.
REQ-025 For SUB, C SHALL be 1 on borrow (A<B unsigned) and O SHALL be signed overflow.
REQ-026 For shifts and ROL, C SHALL be the last bit shifted or rotated out and O SHALL hold; with n=0 the result SHALL be A and C SHALL hold.
REQ-027 For MUL, C SHALL be 1 if the upper product half is nonzero, and O SHALL hold.
REQ-028 When the latched WF=0, FlagsOut SHALL be unchanged; ALUOut and Done SHALL still update.

Reset
REQ-029 When Reset=0 at an edge, ALUOut, FlagsOut, Busy, Done and the counter SHALL become 0 and state SHALL become IDLE, including mid-RUN with the operation discarded and no Done.
REQ-030 Reset SHALL take priority over Start.

Verification (WIDTH=16)
REQ-031 Hold Reset=0 for 2 cycles, then release -> ALUOut=0x0000, FlagsOut=0000, Busy=0, Done=0.
REQ-032 Start, FunSel=10100, A=0x7FFF, B=0x0001, WF=1 -> next cycle ALUOut=0x8000, FlagsOut=0011, Done=1 for one cycle, Busy=0.
REQ-033 Start, FunSel=00110, A=0x0003, B=0x0005, WF=1 -> ALUOut=0x00FE, FlagsOut=0110.
REQ-034 Start, FunSel=11011, A=0x1234, B=0x0004 -> Busy high 5 cycles, then ALUOut=0x2340, FlagsOut=0100, Done pulse; a Start pulse with A=0xFFFF during Busy is ignored.
REQ-035 Start, FunSel=11111, A=0x0100, B=0x0100, WF=1 -> Done 17 cycles after the accepting edge, ALUOut=0x0000, FlagsOut=1100; repeat with WF=0 -> FlagsOut unchanged.
REQ-036 Start MUL, then Reset=0 on the 5th RUN cycle -> all outputs 0, no Done; the next Start (ADD 0x0001+0x0001) -> ALUOut=0x0002.
